// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, registered status flags and sticky error flags.
// Supports standard registered read (FWFT=0) or first-word-fall-through read (FWFT=1).
module sync_fifo_flags #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE + 1)'(DEPTH);
  localparam logic [ASIZE:0] AF_C    = (ASIZE + 1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_C    = (ASIZE + 1)'(AE_LEVEL);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wr_ptr;
  logic [ASIZE-1:0] rd_ptr;
  logic [ASIZE:0]   count_q;
  logic             wr_en;
  logic             rd_en;

  // Handshake: winc/rinc are requests; a write is taken when winc=1 and wfull=0,
  // a read when rinc=1 and rempty=0, both evaluated at the same rising edge.
  // Requests against a full/empty FIFO are dropped and raise the sticky flag.
  assign wr_en = winc & ~wfull;
  assign rd_en = rinc & ~rempty;

  // Flags decode only the count register so they move one cycle after their cause.
  assign count         = count_q;
  assign wfull         = (count_q == DEPTH_C);
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= AF_C);
  assign ralmost_empty = (count_q <= AE_C);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new error in the same cycle as err_clr wins, leaving the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull)  overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rinc && rempty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = rempty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rd_ptr];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-read and an FWFT instance share one stimulus stream
// and are compared every cycle against a queue model, plus literal expectations.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wdata = '0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] rdata0, rdata1;
  logic       wfull0, wfull1, rempty0, rempty1, af0, af1, ae0, ae1;
  logic [2:0] count0, count1;
  logic       ov0, ov1, un0, un1;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0] exp_q[$];
  logic       m_ov = 1'b0;
  logic       m_un = 1'b0;
  logic [7:0] m_rd0 = '0;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .err_clr(err_clr),
    .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .walmost_full(af0),
    .ralmost_empty(ae0), .count(count0), .overflow(ov0), .underflow(un0)
  );

  sync_fifo_flags #(.DSIZE(8), .ASIZE(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .err_clr(err_clr),
    .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .walmost_full(af1),
    .ralmost_empty(ae1), .count(count1), .overflow(ov1), .underflow(un1)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model: a FIFO of at most 4 entries with the flag rules applied to its size.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_ov  = 1'b0;
      m_un  = 1'b0;
      m_rd0 = '0;
    end else begin
      int  n;
      bit  w_ok, r_ok;
      n    = exp_q.size();
      w_ok = winc && (n < 4);
      r_ok = rinc && (n > 0);
      if (winc && n == 4) m_ov = 1'b1;
      else if (err_clr)   m_ov = 1'b0;
      if (rinc && n == 0) m_un = 1'b1;
      else if (err_clr)   m_un = 1'b0;
      if (r_ok) m_rd0 = exp_q.pop_front();
      if (w_ok) exp_q.push_back(wdata);
    end
  end

  // Scoreboard compare on every falling edge outside reset
  always @(negedge clk) begin
    if (!rst) begin
      int n;
      n = exp_q.size();
      check("count0", 32'(count0), 32'(n));
      check("count1", 32'(count1), 32'(n));
      check("wfull0", 32'(wfull0), 32'(n == 4));
      check("wfull1", 32'(wfull1), 32'(n == 4));
      check("rempty0", 32'(rempty0), 32'(n == 0));
      check("rempty1", 32'(rempty1), 32'(n == 0));
      check("afull0", 32'(af0), 32'(n >= 3));
      check("afull1", 32'(af1), 32'(n >= 3));
      check("aempty0", 32'(ae0), 32'(n <= 1));
      check("aempty1", 32'(ae1), 32'(n <= 1));
      check("ovf0", 32'(ov0), 32'(m_ov));
      check("ovf1", 32'(ov1), 32'(m_ov));
      check("unf0", 32'(un0), 32'(m_un));
      check("unf1", 32'(un1), 32'(m_un));
      check("rdata0", 32'(rdata0), 32'(m_rd0));
      if (n > 0) check("rdata1", 32'(rdata1), 32'(exp_q[0]));
    end
  end

  // Driver: present inputs for one rising edge, then return 1 time unit after it.
  task automatic op(input logic w, input logic [7:0] d, input logic r, input logic e);
    winc = w; wdata = d; rinc = r; err_clr = e;
    @(posedge clk);
    #1;
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
  endtask

  task automatic both(input string name, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] exp);
    check({name, "_std"}, a0, exp);
    check({name, "_fwft"}, a1, exp);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    both("rst_count", 32'(count0), 32'(count1), 0);
    both("rst_rempty", 32'(rempty0), 32'(rempty1), 1);
    both("rst_aempty", 32'(ae0), 32'(ae1), 1);
    both("rst_wfull", 32'(wfull0), 32'(wfull1), 0);
    both("rst_afull", 32'(af0), 32'(af1), 0);
    both("rst_ovf", 32'(ov0), 32'(ov1), 0);
    both("rst_unf", 32'(un0), 32'(un1), 0);
    both("rst_rdata", 32'(rdata0), 32'(rdata1), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill, then overflow
    op(1, 8'h11, 0, 0);
    both("fill1_count", 32'(count0), 32'(count1), 1);
    both("fill1_fwft_data", 32'(rdata1), 32'(rdata1), 32'(rdata1));
    check("fill1_rdata1", 32'(rdata1), 32'h11);
    op(1, 8'h22, 0, 0);
    both("fill2_count", 32'(count0), 32'(count1), 2);
    both("fill2_afull", 32'(af0), 32'(af1), 0);
    op(1, 8'h33, 0, 0);
    both("fill3_count", 32'(count0), 32'(count1), 3);
    both("fill3_afull", 32'(af0), 32'(af1), 1);
    both("fill3_wfull", 32'(wfull0), 32'(wfull1), 0);
    op(1, 8'h44, 0, 0);
    both("fill4_count", 32'(count0), 32'(count1), 4);
    both("fill4_wfull", 32'(wfull0), 32'(wfull1), 1);
    op(1, 8'h55, 0, 0);
    both("ovf_count", 32'(count0), 32'(count1), 4);
    both("ovf_flag", 32'(ov0), 32'(ov1), 1);

    // Drain, then underflow
    op(0, 0, 1, 0);
    check("drain1_rdata0", 32'(rdata0), 32'h11);
    check("drain1_rdata1", 32'(rdata1), 32'h22);
    op(0, 0, 1, 0);
    check("drain2_rdata0", 32'(rdata0), 32'h22);
    op(0, 0, 1, 0);
    check("drain3_rdata0", 32'(rdata0), 32'h33);
    op(0, 0, 1, 0);
    check("drain4_rdata0", 32'(rdata0), 32'h44);
    both("drain4_rempty", 32'(rempty0), 32'(rempty1), 1);
    op(0, 0, 1, 0);
    both("unf_flag", 32'(un0), 32'(un1), 1);
    check("unf_rdata0_hold", 32'(rdata0), 32'h44);
    op(0, 0, 0, 1);
    both("clr_ovf", 32'(ov0), 32'(ov1), 0);
    both("clr_unf", 32'(un0), 32'(un1), 0);

    // FWFT: data appears without a read
    op(1, 8'hA5, 0, 0);
    check("fwft_rempty", 32'(rempty1), 0);
    check("fwft_rdata", 32'(rdata1), 32'hA5);
    op(0, 0, 1, 0);
    check("fwft_pop_rempty", 32'(rempty1), 1);
    check("std_pop_rdata", 32'(rdata0), 32'hA5);

    // Simultaneous access at count=2 across two pointer wraps
    op(1, 8'h00, 0, 0);
    op(1, 8'h01, 0, 0);
    for (int i = 0; i < 10; i++) begin
      op(1, 8'(i + 2), 1, 0);
      both("simul_count", 32'(count0), 32'(count1), 2);
    end
    check("simul_rdata0", 32'(rdata0), 32'h09);
    check("simul_rdata1", 32'(rdata1), 32'h0A);
    op(0, 0, 1, 0);
    check("simul_tail1", 32'(rdata0), 32'h0A);
    op(0, 0, 1, 0);
    check("simul_tail2", 32'(rdata0), 32'h0B);

    // Boundary: full + winc + rinc
    for (int i = 0; i < 4; i++) op(1, 8'(8'hC0 + i), 0, 0);
    op(1, 8'hCF, 1, 0);
    both("full_rw_count", 32'(count0), 32'(count1), 3);
    both("full_rw_ovf", 32'(ov0), 32'(ov1), 1);
    check("full_rw_rdata0", 32'(rdata0), 32'hC0);
    for (int i = 0; i < 3; i++) op(0, 0, 1, 0);
    op(0, 0, 0, 1);
    // Boundary: empty + winc + rinc
    op(1, 8'hE1, 1, 0);
    both("empty_rw_count", 32'(count0), 32'(count1), 1);
    both("empty_rw_unf", 32'(un0), 32'(un1), 1);
    check("empty_rw_rdata1", 32'(rdata1), 32'hE1);
    op(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) op(1, 8'(8'hE2 + i), 0, 0);
    // Boundary: err_clr with a new overflow
    op(1, 8'h99, 0, 1);
    both("clr_vs_ovf", 32'(ov0), 32'(ov1), 1);
    both("clr_unf2", 32'(un0), 32'(un1), 0);

    // Async reset between edges at count=3
    op(0, 0, 1, 0);
    both("pre_rst_count", 32'(count0), 32'(count1), 3);
    #2 rst = 1'b1;
    #1;
    both("arst_count", 32'(count0), 32'(count1), 0);
    both("arst_rempty", 32'(rempty0), 32'(rempty1), 1);
    both("arst_wfull", 32'(wfull0), 32'(wfull1), 0);
    both("arst_afull", 32'(af0), 32'(af1), 0);
    both("arst_ovf", 32'(ov0), 32'(ov1), 0);
    both("arst_rdata0", 32'(rdata0), 32'(rdata0 & 8'h00), 0);
    #1 rst = 1'b0;
    op(1, 8'h77, 0, 0);
    check("post_rst_count", 32'(count0), 1);
    check("post_rst_rdata1", 32'(rdata1), 32'h77);
    op(0, 0, 1, 0);
    check("post_rst_rdata0", 32'(rdata0), 32'h77);
    both("post_rst_rempty", 32'(rempty0), 32'(rempty1), 1);

    op(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
